// File: rtl/ga_pkg.sv
// ga_pkg: shared chromosome typedef macros, FSM states, LFSR taps
// and the gene-match fitness helper for the GA generation engine.
`ifndef GA_GENE_T
`define GA_GENE_T(W) logic [(W)-1:0]
`endif
`ifndef GA_CHROM_T
`define GA_CHROM_T(L, W) logic [(L)*(W)-1:0]
`endif

package ga_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        SORT,
        BREED,
        DONE
    } ga_state_e;

    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
    localparam logic [15:0] LFSR2_TAPS  = 16'hB400;
    localparam int          MAX_CHROM_W = 256;

    // Chromosomes are zero-extended to MAX_CHROM_W; only len genes count.
    function automatic logic [5:0] match_count(
        input logic [MAX_CHROM_W-1:0] chrom,
        input logic [MAX_CHROM_W-1:0] target,
        input int                     len,
        input int                     gene_w
    );
        logic [MAX_CHROM_W-1:0] diff;
        logic [7:0]             mask;
        logic [5:0]             n;
        diff = chrom ^ target;
        mask = 8'((9'd1 << gene_w) - 9'd1);
        n    = '0;
        for (int g = 0; g < 32; g++) begin
            if (g < len && (diff[g*gene_w +: 8] & mask) == 8'd0)
                n = n + 6'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/ga_lfsr.sv
// ga_lfsr: right-shifting Galois LFSR that advances only when step is high.
// Synchronous active-high reset loads SEED.
module ga_lfsr #(
    parameter int           W    = 32,
    parameter logic [W-1:0] TAPS = '1,
    parameter logic [W-1:0] SEED = W'(1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= SEED;
        else if (step)
            q <= q[0] ? ((q >> 1) ^ TAPS) : (q >> 1);
    end

endmodule

// File: rtl/ga_generation_engine.sv
// ga_generation_engine: one GA generation per start (evaluate, rank, breed).
// Define GA_MUTATION_EN to add single-gene mutation of bred children.
module ga_generation_engine
    import ga_pkg::*;
#(
    parameter int          GENOME_LENGTH = 28,
    parameter int          GENE_W        = 8,
    parameter int          POP_SIZE      = 10,
    parameter int          ELITE         = 2,
    parameter logic [31:0] SEED          = 32'hACE1_2024,
    parameter int          MUT_SHIFT     = 3,
    localparam int         IDX_W         = $clog2(POP_SIZE),
    localparam int         FIT_W         = $clog2(GENOME_LENGTH + 1),
    localparam int         CW            = GENOME_LENGTH * GENE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CW-1:0]    target,
    input  logic             pop_wr_en,
    input  logic [IDX_W-1:0] pop_wr_idx,
    input  logic [CW-1:0]    pop_wr_data,
    input  logic [IDX_W-1:0] pop_rd_idx,
    output logic [CW-1:0]    pop_rd_data,
    output logic             busy,
    output logic             done,
    output logic [FIT_W-1:0] best_fitness,
    output logic [IDX_W-1:0] best_idx,
    output logic             solved,
    output logic [15:0]      gen_count
);

    typedef `GA_CHROM_T(GENOME_LENGTH, GENE_W) chromosome_t;
    typedef `GA_GENE_T(GENE_W) gene_t;

    localparam int               HALF    = POP_SIZE / 2;
    localparam int               N_CHILD = POP_SIZE - ELITE;
    localparam logic [IDX_W-1:0] LAST_P  = IDX_W'(POP_SIZE - 1);
    localparam logic [IDX_W-1:0] LAST_B  = IDX_W'(N_CHILD - 1);

    if (GENOME_LENGTH < 2 || GENOME_LENGTH > 32 ||
        GENE_W < 1 || GENE_W > 8 ||
        POP_SIZE < 4 || POP_SIZE > 32 || (POP_SIZE % 2) != 0 ||
        ELITE < 1 || ELITE > POP_SIZE / 2 ||
        SEED == 32'd0 || MUT_SHIFT < 1 || MUT_SHIFT > 8) begin : g_bad_param
        $error("ga_generation_engine: illegal parameter set");
    end

    ga_state_e        state;
    ga_state_e        state_nx;
    logic [IDX_W-1:0] cnt;

    chromosome_t      pop      [POP_SIZE];
    chromosome_t      next_pop [POP_SIZE];
    logic [FIT_W-1:0] fit      [POP_SIZE];
    logic [IDX_W-1:0] rank     [POP_SIZE];
    logic [IDX_W-1:0] rank_sorted [POP_SIZE];

    logic [IDX_W-1:0] idx_a;
    logic [IDX_W-1:0] idx_b;
    chromosome_t      par_a;
    chromosome_t      par_b;
    chromosome_t      child;
    logic [31:0]      lfsr_q;
    logic             lfsr_step;
    logic             lfsr_unused;

    assign lfsr_step = (state == BREED);

    ga_lfsr #(
        .W    (32),
        .TAPS (LFSR_TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

`ifdef GA_MUTATION_EN
    logic [15:0] lfsr2_q;
    logic [5:0]  mut_gene;
    gene_t       mut_val;

    ga_lfsr #(
        .W    (16),
        .TAPS (LFSR2_TAPS),
        .SEED (SEED[15:0] | 16'h0001)
    ) u_lfsr2 (
        .clk  (clk),
        .rst  (rst),
        .step (lfsr_step),
        .q    (lfsr2_q)
    );

    assign mut_gene    = 6'(int'(lfsr2_q[15:8]) % GENOME_LENGTH);
    assign mut_val     = lfsr2_q[GENE_W-1:0];
    assign lfsr_unused = ^{lfsr_q, lfsr2_q};
`else
    assign lfsr_unused = ^lfsr_q;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = EVAL;
            EVAL:    if (cnt == LAST_P) state_nx = SORT;
            SORT:    if (cnt == LAST_P) state_nx = BREED;
            BREED:   if (cnt == LAST_B) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE || state_nx != state)
            cnt <= '0;
        else
            cnt <= cnt + IDX_W'(1);
    end

    // One odd-even transposition pass; strict compare keeps ties stable.
    always_comb begin
        for (int k = 0; k < POP_SIZE; k++)
            rank_sorted[k] = rank[k];
        for (int k = 0; k + 1 < POP_SIZE; k++) begin
            if ((k % 2) == int'(cnt[0]) &&
                fit[rank[k+1]] > fit[rank[k]]) begin
                rank_sorted[k]   = rank[k+1];
                rank_sorted[k+1] = rank[k];
            end
        end
    end

    assign idx_a = IDX_W'(int'(cnt) % HALF);
    assign idx_b = IDX_W'((int'(cnt) + 1) % HALF);
    assign par_a = pop[rank[idx_a]];
    assign par_b = pop[rank[idx_b]];

    always_comb begin
        child = par_b;
        for (int g = 0; g < GENOME_LENGTH; g++) begin
            if (lfsr_q[g])
                child[g*GENE_W +: GENE_W] = par_a[g*GENE_W +: GENE_W];
        end
`ifdef GA_MUTATION_EN
        if (lfsr2_q[MUT_SHIFT-1:0] == '0)
            child[mut_gene*GENE_W +: GENE_W] = mut_val;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < POP_SIZE; i++) begin
                pop[i]      <= '0;
                next_pop[i] <= '0;
                fit[i]      <= '0;
                rank[i]     <= '0;
            end
            done         <= 1'b0;
            best_fitness <= '0;
            best_idx     <= '0;
            solved       <= 1'b0;
            gen_count    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop_wr_en && int'(pop_wr_idx) < POP_SIZE)
                        pop[pop_wr_idx] <= pop_wr_data;
                    if (start)
                        solved <= 1'b0;
                end
                EVAL: begin
                    fit[cnt] <= FIT_W'(match_count(MAX_CHROM_W'(pop[cnt]),
                                                   MAX_CHROM_W'(target),
                                                   GENOME_LENGTH, GENE_W));
                    rank[cnt] <= cnt;
                end
                SORT: begin
                    for (int k = 0; k < POP_SIZE; k++)
                        rank[k] <= rank_sorted[k];
                end
                BREED: next_pop[IDX_W'(ELITE) + cnt] <= child;
                DONE: begin
                    for (int i = 0; i < POP_SIZE; i++) begin
                        if (i < ELITE)
                            pop[i] <= pop[rank[i]];
                        else
                            pop[i] <= next_pop[i];
                    end
                    done         <= 1'b1;
                    best_idx     <= rank[0];
                    best_fitness <= fit[rank[0]];
                    gen_count    <= gen_count + 16'd1;
                    if (fit[rank[0]] == FIT_W'(GENOME_LENGTH))
                        solved <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign pop_rd_data = (int'(pop_rd_idx) < POP_SIZE) ? pop[pop_rd_idx] : '0;

endmodule

// File: tb/tb_ga_generation_engine.sv
// tb_ga_generation_engine: scoreboard bench for ga_generation_engine
// using a behavioural rank/breed model at default parameters.
module tb_ga_generation_engine;

    localparam int          GL   = 28;
    localparam int          GW   = 8;
    localparam int          P    = 10;
    localparam int          EL   = 2;
    localparam int          CW   = GL * GW;
    localparam logic [31:0] SEED = 32'hACE1_2024;

    typedef logic [CW-1:0]         chrom_t;
    typedef logic [P-1:0][CW-1:0]  popv_t;
    typedef struct {
        int    best_fit;
        int    best_idx;
        int    gen;
        bit    solved;
        popv_t pop;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    chrom_t      tgt;
    logic        pop_wr_en;
    logic [3:0]  pop_wr_idx;
    chrom_t      pop_wr_data;
    logic [3:0]  pop_rd_idx;
    chrom_t      pop_rd_data;
    logic        busy;
    logic        done;
    logic [4:0]  best_fitness;
    logic [3:0]  best_idx;
    logic        solved;
    logic [15:0] gen_count;

    popv_t       mpop;
    int          mrank [P];
    logic [31:0] mlfsr;
    logic [15:0] mlfsr2;
    int          mgen;
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    ga_generation_engine dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .target       (tgt),
        .pop_wr_en    (pop_wr_en),
        .pop_wr_idx   (pop_wr_idx),
        .pop_wr_data  (pop_wr_data),
        .pop_rd_idx   (pop_rd_idx),
        .pop_rd_data  (pop_rd_data),
        .busy         (busy),
        .done         (done),
        .best_fitness (best_fitness),
        .best_idx     (best_idx),
        .solved       (solved),
        .gen_count    (gen_count)
    );

    always #5 clk = ~clk;

    function automatic int fit_of(chrom_t c, chrom_t t);
        int n = 0;
        for (int g = 0; g < GL; g++)
            if (c[g*GW +: GW] == t[g*GW +: GW]) n++;
        return n;
    endfunction

    function automatic chrom_t miss(chrom_t t, int lo, int hi);
        chrom_t c = t;
        for (int g = lo; g < hi; g++)
            c[g*GW +: GW] = ~t[g*GW +: GW];
        return c;
    endfunction

    task automatic model_reset();
        mpop   = '0;
        mlfsr  = SEED;
        mlfsr2 = SEED[15:0] | 16'h0001;
        mgen   = 0;
        sb.delete();
    endtask

    // Rank by counting better-or-earlier slots, then breed.
    task automatic model_gen();
        exp_t   e;
        int     f [P];
        int     pos;
        popv_t  nx;
        chrom_t a, b;
        for (int s = 0; s < P; s++) f[s] = fit_of(mpop[s], tgt);
        for (int s = 0; s < P; s++) begin
            pos = 0;
            for (int t = 0; t < P; t++)
                if (f[t] > f[s] || (f[t] == f[s] && t < s)) pos++;
            mrank[pos] = s;
        end
        nx = '0;
        for (int i = 0; i < EL; i++) nx[i] = mpop[mrank[i]];
        for (int c = 0; c < P - EL; c++) begin
            a = mpop[mrank[c % (P/2)]];
            b = mpop[mrank[(c + 1) % (P/2)]];
            for (int g = 0; g < GL; g++)
                nx[EL+c][g*GW +: GW] = mlfsr[g] ? a[g*GW +: GW] : b[g*GW +: GW];
`ifdef GA_MUTATION_EN
            if (mlfsr2[2:0] == 3'd0)
                nx[EL+c][(int'(mlfsr2[15:8]) % GL)*GW +: GW] = mlfsr2[7:0];
            mlfsr2 = mlfsr2[0] ? ((mlfsr2 >> 1) ^ 16'hB400) : (mlfsr2 >> 1);
`endif
            mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ 32'h8020_0003) : (mlfsr >> 1);
        end
        mgen++;
        e.best_fit = f[mrank[0]];
        e.best_idx = mrank[0];
        e.gen      = mgen;
        e.solved   = (f[mrank[0]] == GL);
        e.pop      = nx;
        mpop       = nx;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        start       = 1'b0;
        pop_wr_en   = 1'b0;
        pop_wr_idx  = '0;
        pop_wr_data = '0;
        pop_rd_idx  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic load_slot(int idx, chrom_t d);
        pop_wr_en   = 1'b1;
        pop_wr_idx  = 4'(idx);
        pop_wr_data = d;
        @(negedge clk);
        pop_wr_en = 1'b0;
        if (idx < P) mpop[idx] = d;
    endtask

    task automatic run_gen(input string tag, input bit disturb);
        exp_t e;
        int   lat = 0;
        int   wr_slot;
        model_gen();
        wr_slot = mrank[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
        end
        for (int n = 1; n <= 60; n++) begin
            if (disturb && n == 5) begin
                start       = 1'b1;
                pop_wr_en   = 1'b1;
                pop_wr_idx  = 4'(wr_slot);
                pop_wr_data = '1;
            end
            if (disturb && n == 6) begin
                start     = 1'b0;
                pop_wr_en = 1'b0;
            end
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        start     = 1'b0;
        pop_wr_en = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (lat != 29) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want 29 (0 = timeout)", tag, lat);
        end
        n_checks++;
        if (best_fitness !== 5'(e.best_fit)) begin
            n_fail++;
            $display("FAIL %s best_fitness: got %0d want %0d", tag, best_fitness, e.best_fit);
        end
        n_checks++;
        if (best_idx !== 4'(e.best_idx)) begin
            n_fail++;
            $display("FAIL %s best_idx: got %0d want %0d", tag, best_idx, e.best_idx);
        end
        n_checks++;
        if (gen_count !== 16'(e.gen)) begin
            n_fail++;
            $display("FAIL %s gen_count: got %0d want %0d", tag, gen_count, e.gen);
        end
        n_checks++;
        if (solved !== e.solved) begin
            n_fail++;
            $display("FAIL %s solved: got %b want %b", tag, solved, e.solved);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse: got done=%b busy=%b want 0 0", tag, done, busy);
        end
        for (int i = 0; i < P; i++) begin
            pop_rd_idx = 4'(i);
            #1;
            n_checks++;
            if (pop_rd_data !== e.pop[i]) begin
                n_fail++;
                $display("FAIL %s pop[%0d]: got %h want %h", tag, i, pop_rd_data, e.pop[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic check_val(string name, logic [CW-1:0] got, logic [CW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic read_slot(int idx, output chrom_t d);
        pop_rd_idx = 4'(idx);
        #1;
        d = pop_rd_data;
    endtask

    task automatic test_reset();
        chrom_t d;
        do_reset();
        check_val("reset_busy", CW'(busy), '0);
        check_val("reset_done", CW'(done), '0);
        check_val("reset_best_fitness", CW'(best_fitness), '0);
        check_val("reset_best_idx", CW'(best_idx), '0);
        check_val("reset_solved", CW'(solved), '0);
        check_val("reset_gen_count", CW'(gen_count), '0);
        load_slot(12, '1);
        read_slot(12, d);
        check_val("oob_read", d, '0);
        read_slot(0, d);
        check_val("oob_write_slot0", d, '0);
        read_slot(9, d);
        check_val("oob_write_slot9", d, '0);
        @(negedge clk);
    endtask

    task automatic test_all_match();
        tgt = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int s = 0; s < P; s++) load_slot(s, tgt);
        run_gen("all_match", 1'b0);
        check_val("all_match_best28", CW'(best_fitness), CW'(28));
        check_val("all_match_solved", CW'(solved), CW'(1));
        check_val("all_match_gen1", CW'(gen_count), CW'(1));
    endtask

    task automatic test_ranking();
        chrom_t o9, o8, d;
        for (int s = 0; s < P; s++) load_slot(s, miss(tgt, s, GL));
        o9 = mpop[9];
        o8 = mpop[8];
        run_gen("ranking", 1'b0);
        check_val("ranking_best_idx", CW'(best_idx), CW'(9));
        check_val("ranking_best_fit", CW'(best_fitness), CW'(9));
        check_val("ranking_solved", CW'(solved), '0);
        read_slot(0, d);
        check_val("ranking_slot0", d, o9);
        read_slot(1, d);
        check_val("ranking_slot1", d, o8);
        @(negedge clk);
    endtask

    task automatic test_tie();
        chrom_t o3, o6, d;
        for (int s = 0; s < P; s++) begin
            if (s == 3)      load_slot(s, miss(tgt, 20, GL));
            else if (s == 6) load_slot(s, miss(tgt, 0, 8));
            else             load_slot(s, miss(tgt, 0, GL));
        end
        o3 = mpop[3];
        o6 = mpop[6];
        run_gen("tie", 1'b0);
        check_val("tie_best_idx", CW'(best_idx), CW'(3));
        check_val("tie_best_fit", CW'(best_fitness), CW'(20));
        read_slot(0, d);
        check_val("tie_slot0", d, o3);
        read_slot(1, d);
        check_val("tie_slot1", d, o6);
        @(negedge clk);
    endtask

    task automatic load_random();
        chrom_t c;
        for (int s = 0; s < P; s++) begin
            c = tgt;
            for (int g = 0; g < GL; g++)
                if ($urandom_range(0, 1) == 1) c[g*GW +: GW] = 8'($urandom);
            load_slot(s, c);
        end
    endtask

    task automatic test_crossover();
        popv_t  old;
        chrom_t a, b, d;
        int     bad;
        load_random();
        old = mpop;
        run_gen("crossover", 1'b0);
`ifndef GA_MUTATION_EN
        for (int c = 0; c < P - EL; c++) begin
            a = old[mrank[c % (P/2)]];
            b = old[mrank[(c + 1) % (P/2)]];
            read_slot(EL + c, d);
            bad = 0;
            for (int g = 0; g < GL; g++)
                if (d[g*GW +: GW] !== a[g*GW +: GW] && d[g*GW +: GW] !== b[g*GW +: GW])
                    bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL gene_origin child %0d: got %0d foreign genes want 0", EL + c, bad);
            end
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid_run();
        chrom_t d;
        int     nz = 0;
        load_random();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_busy", CW'(busy), '0);
        check_val("midrst_done", CW'(done), '0);
        check_val("midrst_gen_count", CW'(gen_count), '0);
        for (int s = 0; s < P; s++) begin
            read_slot(s, d);
            if (d !== '0) nz++;
        end
        check_val("midrst_pop_nonzero_slots", CW'(nz), '0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        load_random();
        run_gen("disturbed", 1'b1);
        run_gen("second", 1'b0);
        check_val("b2b_gen_count", CW'(gen_count), CW'(2));
    endtask

    initial begin
        tgt = '0;
        test_reset();
        test_all_match();
        test_ranking();
        test_tie();
        test_crossover();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
